// File: rtl/t03_dcache_ctrl_if.sv
// CPU-side and memory-side handshake bundle for the direct-mapped data cache.
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface t03_dcache_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              hit;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, hit, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, hit, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/t03_dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// one-word lines, single-cycle flush and saturating hit/miss counters.
module t03_dcache_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int NUM_LINES = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  t03_dcache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, FLUSH} state_e;

  state_e                state_q, state_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [DATA_W-1:0]     data_q [NUM_LINES];
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  idx, l_idx;
  logic [TAG_W-1:0]  tag, l_tag;
  logic              hit_c, l_hit;
  logic              arr_we;
  logic [DATA_W-1:0] arr_data;
  logic              ready_c;
  logic [DATA_W-1:0] rdata_c;
  logic              hit_inc, miss_inc;
  logic              unused_addr_lsb;

  assign idx   = bus.cpu_addr[IDX_W+1:2];
  assign tag   = bus.cpu_addr[ADDR_W-1:IDX_W+2];
  assign hit_c = valid_q[idx] && (tag_q[idx] == tag);

  // In FILL/WRITE the line is addressed from the latched request, not the live bus.
  assign l_idx = mem_addr_q[IDX_W+1:2];
  assign l_tag = mem_addr_q[ADDR_W-1:IDX_W+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    arr_we      = 1'b0;
    arr_data    = bus.mem_rdata;
    ready_c     = 1'b0;
    rdata_c     = '0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (bus.cpu_write) begin
          mem_addr_d  = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_d = bus.cpu_wdata;
          mem_write_d = 1'b1;
          miss_inc    = !hit_c;
          state_d     = WRITE;
        end else if (bus.cpu_read) begin
          if (hit_c) begin
            ready_c = 1'b1;
            rdata_c = data_q[idx];
            hit_inc = 1'b1;
          end else begin
            mem_addr_d = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
            mem_read_d = 1'b1;
            miss_inc   = 1'b1;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          arr_we         = 1'b1;
          valid_d[l_idx] = 1'b1;
          ready_c        = 1'b1;
          rdata_c        = bus.mem_rdata;
          mem_read_d     = 1'b0;
          state_d        = IDLE;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          arr_we      = l_hit;
          arr_data    = mem_wdata_q;
          ready_c     = 1'b1;
          mem_write_d = 1'b0;
          state_d     = IDLE;
        end
      end
      FLUSH: begin
        valid_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    hit_cnt_d  = (hit_inc  && hit_cnt_q  != '1) ? hit_cnt_q  + CNT_W'(1) : hit_cnt_q;
    miss_cnt_d = (miss_inc && miss_cnt_q != '1) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag/data need no reset: valid gates them, and reset forces IDLE so arr_we stays low.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_q[l_idx]  <= l_tag;
      data_q[l_idx] <= arr_data;
    end
  end

  assign bus.hit       = hit_c;
  assign bus.cpu_ready = ready_c;
  assign bus.cpu_rdata = rdata_c;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;
endmodule

// File: doc/t03_dcache_ctrl.md
# t03_dcache_ctrl

Parametrised direct-mapped, write-through, no-write-allocate data cache controller between the CPU data port and the memory/wishbone data interface. It holds tag, valid and data arrays with NUM_LINES entries. Read hits are served combinationally. Read misses are refilled through a memory handshake. Writes go through to memory and update the line only on a hit. Includes a one-cycle flush and saturating hit/miss counters for performance bring-up.

## Interface

Parameters:
- DATA_W, 32: data word width.
- ADDR_W, 32: byte address width.
- NUM_LINES, 8: number of one-word lines; power of 2, at least 2. IDX_W = log2(NUM_LINES).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nrst  in  1  asynchronous, active-low reset.
- cpu_read  in  1  read request; held until cpu_ready.
- cpu_write  in  1  write request; held until cpu_ready. Write wins if both cpu_read and cpu_write are high.
- cpu_addr  in  ADDR_W  byte address. Index = cpu_addr[IDX_W+1:2]; tag = cpu_addr[ADDR_W-1:IDX_W+2]; bits [1:0] are ignored.
- cpu_wdata  in  DATA_W  write data.
- flush  in  1  invalidate all lines; level, sampled only in IDLE.
- cpu_rdata  out  DATA_W  read data; valid only while cpu_ready is high with a read; 0 otherwise.
- cpu_ready  out  1  one-cycle completion strobe.
- hit  out  1  combinational: valid[idx] and tag match for the current cpu_addr.
- mem_read  out  1  memory read request, registered.
- mem_write  out  1  memory write request, registered.
- mem_addr  out  ADDR_W  latched request address, word aligned (bits [1:0] = 0).
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory completion, one cycle. Ignored in IDLE and FLUSH.
- hit_count  out  CNT_W  saturating count of read hits.
- miss_count  out  CNT_W  saturating count of read misses plus write misses.

## Operation

- States: IDLE, FILL, WRITE, FLUSH.
- IDLE, flush high: go to FLUSH. Flush takes priority over pending requests.
- IDLE, cpu_write (no flush):
  - Latch addr/wdata into mem_addr/mem_wdata.
  - Set mem_write, go to WRITE.
  - If the write misses, increment miss_count.
- IDLE, cpu_read hit (no write, no flush):
  - Same cycle: cpu_ready=1, cpu_rdata=data[idx].
  - Increment hit_count. Stay in IDLE.
- IDLE, cpu_read miss:
  - Latch address, set mem_read, go to FILL.
  - Increment miss_count.
- FILL:
  - Hold mem_read until mem_ack.
  - On the ack cycle: write data[idx]=mem_rdata, tag[idx]=latched tag, valid[idx]=1. Drive cpu_ready=1 and cpu_rdata=mem_rdata. Clear mem_read on the next edge and return to IDLE.
  - A conflicting line is simply overwritten; no write-back is needed.
- WRITE:
  - Hold mem_write until mem_ack.
  - On the ack cycle: cpu_ready=1. If the latched address hits, data[idx]=mem_wdata. On a miss, the arrays are unchanged.
  - Return to IDLE.
- FLUSH: clear all valid bits in one cycle; return to IDLE. cpu_ready stays 0 during FLUSH.
- Index and tag are computed from the latched address in FILL and WRITE, not from live cpu_addr.
- Counters saturate at all-ones and do not wrap. They are cleared only by reset.
- Reset values: state IDLE; all valid=0; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; cpu_ready=0; cpu_rdata=0; counters 0.
- Reset asserted mid-FILL or mid-WRITE aborts the transaction immediately. mem_read/mem_write drop asynchronously and no array update occurs.
- The data and tag arrays need no reset; valid gates them.

## Timing

- Read hit: 0 wait cycles; cpu_ready is high in the request cycle.
- Read miss:
  - Request seen at edge T.
  - mem_read high from T+1.
  - Ack in cycle T+k gives cpu_ready in the same cycle T+k.
  - mem_read low from edge T+k+1.
- Write: same as a read miss, using mem_write and the WRITE state.
- Minimum miss/write latency is 2 cycles (ack in the first request cycle).
- Back-to-back: a new request may be accepted in the cycle after cpu_ready. The CPU must drop or change its request after cpu_ready.
- Flush: one cycle in FLUSH. A request held during flush is evaluated in IDLE on the following cycle and misses.
- mem_ack while in IDLE or FLUSH has no effect.

## Test plan

- Reset, then read 0x0000_0010 with mem_rdata=0xDEAD_BEEF and ack after 3 cycles: cpu_ready in the ack cycle with 0xDEAD_BEEF; miss_count=1. Re-read: 0-cycle hit, 0xDEAD_BEEF, hit_count=1.
- Write 0x0000_0010 with 0x1234_5678 (hit): mem_write/mem_addr/mem_wdata held until ack. Subsequent read hits with 0x1234_5678 and no mem_read.
- Write miss to 0x0000_0040: goes to memory; a following read of 0x40 misses (no allocate); miss_count increments twice.
- Conflict, NUM_LINES=8: fill 0x10, then fill 0x30 (same index, different tag). Reading 0x10 misses again.
- Flush after filling 4 lines: every line then misses.
- Flush together with cpu_read in IDLE: flush is taken first and the read misses afterwards.
- Reset asserted mid-FILL: mem_read=0 immediately and all lines invalid.
- Counter saturation with CNT_W=2: 5 hits leave hit_count=3.
